// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size encodings,
// FSM state type, and the byte-lane helpers used for stores and loads.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte-write-enable mask for a store of the given size at byte offset off.
  function automatic logic [3:0] store_be(input logic [1:0] off, input logic [1:0] size);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across lanes so the mask picks the right bytes.
  function automatic logic [31:0] store_data(input logic [31:0] wdata, input logic [1:0] size);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Pick the addressed lane(s) out of a memory word and zero/sign extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = {{24{sgn & b[7]}}, b};
      SZ_HALF: res = {{16{sgn & h[15]}}, h};
      SZ_WORD: res = word;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a registered read
// port. Each byte lane is its own array so every lane maps onto block RAM
// with a plain write enable. Contents are never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_rdata;

      // Lane write on its enable; read data only refreshes on a read strobe so it holds steady.
      always_ff @(posedge clk) begin
        if (i_be[gi]) begin
          r_mem[i_idx] <= i_wdata[8*gi +: 8];
        end
        if (i_re) begin
          r_rdata <= r_mem[i_idx];
        end
      end

      assign o_rdata[8*gi +: 8] = r_rdata;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store request, waits WAIT_CYCLES,
// then presents a response held until the initiator takes it.
// Optional build macro DMEM_MISALIGN_CHECK_EN: misaligned half/word accesses
// are flagged as errors instead of having their low address bits cleared.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [11:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic        r_wr;
  logic [11:0] r_addr;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_wdata;
  logic        r_err;

  logic        w_accept;
  logic        w_enter_resp;
  logic [11:0] w_in_addr;
  logic        w_in_err;
  logic        w_cur_wr;
  logic [11:0] w_cur_addr;
  logic [1:0]  w_cur_size;
  logic [31:0] w_cur_wdata;
  logic        w_cur_err;
  logic [3:0]  w_arr_be;
  logic [31:0] w_arr_wdata;
  logic [AW-1:0] w_arr_idx;
  logic [31:0] w_arr_rdata;

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid & req_ready;

  // Classify the incoming request: reserved size errors, and alignment handling.
  always_comb begin
    w_in_addr = req_addr;
    w_in_err  = (req_size == SZ_RSVD);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (req_size == SZ_HALF && req_addr[0]) begin
      w_in_err = 1'b1;
    end
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) begin
      w_in_err = 1'b1;
    end
`else
    if (req_size == SZ_HALF) begin
      w_in_addr[0] = 1'b0;
    end
    if (req_size == SZ_WORD) begin
      w_in_addr[1:0] = 2'b00;
    end
`endif
  end

  // Next-state logic; also flags the edge on which the memory is accessed.
  always_comb begin
    w_state_next = r_state;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_next = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture the request on acceptance and count down the wait states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 4'd0;
      r_wr     <= 1'b0;
      r_addr   <= 12'h0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_wdata  <= 32'h0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= 4'(WAIT_CYCLES);
      r_wr     <= req_wr;
      r_addr   <= w_in_addr;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_wdata  <= req_wdata;
      r_err    <= w_in_err;
    end else if (r_state == WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // With zero wait states the memory is accessed on the accepting edge, before
  // the capture registers hold the request, so take the fields straight from the port.
  assign w_cur_wr    = (r_state == IDLE) ? req_wr    : r_wr;
  assign w_cur_addr  = (r_state == IDLE) ? w_in_addr : r_addr;
  assign w_cur_size  = (r_state == IDLE) ? req_size  : r_size;
  assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_cur_err   = (r_state == IDLE) ? w_in_err  : r_err;

  assign w_arr_be    = (w_enter_resp && w_cur_wr && !w_cur_err) ?
                       store_be(w_cur_addr[1:0], w_cur_size) : 4'b0000;
  assign w_arr_wdata = store_data(w_cur_wdata, w_cur_size);
  assign w_arr_idx   = AW'(32'(w_cur_addr[11:2]) % DEPTH_WORDS);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .i_re   (w_enter_resp),
    .i_be   (w_arr_be),
    .i_idx  (w_arr_idx),
    .i_wdata(w_arr_wdata),
    .o_rdata(w_arr_rdata)
  );

  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = rsp_valid & r_err;
  assign rsp_rdata = (rsp_valid && !r_err && !r_wr) ?
                     load_extend(w_arr_rdata, r_addr[1:0], r_size, r_signed) : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for the main
// scenarios and a WAIT_CYCLES=0, 16-word instance for back-to-back and wrap.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v2 = 1'b0;
  logic        v0 = 1'b0;
  logic        wr = 1'b0;
  logic [11:0] addr = 12'h0;
  logic [1:0]  size = 2'b00;
  logic        sgn = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        rsp_ready = 1'b1;

  logic        rdy2, val2, err2;
  logic [31:0] rd2;
  logic        rdy0, val0, err0;
  logic [31:0] rd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_wr(wr),
    .req_addr(addr), .req_size(size), .req_signed(sgn), .req_wdata(wdata),
    .rsp_valid(val2), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(err2)
  );

  dmem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(16)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_wr(wr),
    .req_addr(addr), .req_size(size), .req_signed(sgn), .req_wdata(wdata),
    .rsp_valid(val0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(err0)
  );

  // Drive one request to the selected instance (sel=1 -> dut0), returning the
  // response, the number of edges from acceptance to rsp_valid, and accept time.
  task automatic run_txn(input bit sel, input logic w, input logic [11:0] a,
                         input logic [1:0] s, input logic sg, input logic [31:0] d,
                         output logic [31:0] o_rd, output logic o_err,
                         output int o_lat, output time o_tacc);
    int guard;
    @(negedge clk);
    wr = w; addr = a; size = s; sgn = sg; wdata = d; rsp_ready = 1'b1;
    if (sel) v0 = 1'b1; else v2 = 1'b1;
    guard = 0;
    while (!(sel ? rdy0 : rdy2) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    o_tacc = $time;
    @(negedge clk);
    v0 = 1'b0; v2 = 1'b0;
    o_lat = 1;
    while (!(sel ? val0 : val2) && o_lat < 20) begin
      @(negedge clk);
      o_lat++;
    end
    o_rd  = sel ? rd0 : rd2;
    o_err = sel ? err0 : err2;
    $display("txn dut%0d wr=%0b addr=%03h size=%0d sgn=%0b wdata=%08h -> rdata=%08h err=%0b lat=%0d",
             sel ? 0 : 2, w, a, s, sg, d, o_rd, o_err, o_lat);
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset req_ready got %b exp 1", rdy2); end
    checks++; if (val2 !== 1'b0) begin errors++; $display("FAIL reset rsp_valid got %b exp 0", val2); end
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset rsp_rdata got %h exp 0", rd2); end
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL reset rsp_err got %b exp 0", err2); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset0 req_ready got %b exp 1", rdy0); end
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL reset0 rsp_valid got %b exp 0", val0); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] r; logic e; int lat; time t;
    run_txn(1'b0, 1'b1, 12'h010, 2'b10, 1'b0, 32'hDEADBEEF, r, e, lat, t);
    checks++; if (lat !== 3) begin errors++; $display("FAIL st_word latency got %0d exp 3", lat); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL st_word rdata got %h exp 0", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL st_word err got %b exp 0", e); end
    run_txn(1'b0, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, r, e, lat, t);
    checks++; if (lat !== 3) begin errors++; $display("FAIL ld_word latency got %0d exp 3", lat); end
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word rdata got %h exp deadbeef", r); end
  endtask

  task automatic test_byte_half();
    logic [31:0] r; logic e; int lat; time t;
    run_txn(1'b0, 1'b1, 12'h013, 2'b00, 1'b0, 32'h00000080, r, e, lat, t);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL st_byte err got %b exp 0", e); end
    run_txn(1'b0, 1'b0, 12'h013, 2'b00, 1'b1, 32'h0, r, e, lat, t);
    checks++; if (r !== 32'hFFFFFF80) begin errors++; $display("FAIL ld_byte_s rdata got %h exp ffffff80", r); end
    run_txn(1'b0, 1'b0, 12'h013, 2'b00, 1'b0, 32'h0, r, e, lat, t);
    checks++; if (r !== 32'h00000080) begin errors++; $display("FAIL ld_byte_u rdata got %h exp 00000080", r); end
    run_txn(1'b0, 1'b0, 12'h010, 2'b10, 1'b1, 32'h0, r, e, lat, t);
    checks++; if (r !== 32'h80ADBEEF) begin errors++; $display("FAIL ld_word2 rdata got %h exp 80adbeef", r); end
    run_txn(1'b0, 1'b0, 12'h010, 2'b00, 1'b1, 32'h0, r, e, lat, t);
    checks++; if (r !== 32'hFFFFFFEF) begin errors++; $display("FAIL ld_byte0_s rdata got %h exp ffffffef", r); end
    run_txn(1'b0, 1'b0, 12'h012, 2'b01, 1'b1, 32'h0, r, e, lat, t);
    checks++; if (r !== 32'hFFFF80AD) begin errors++; $display("FAIL ld_half_s rdata got %h exp ffff80ad", r); end
    run_txn(1'b0, 1'b0, 12'h010, 2'b01, 1'b0, 32'h0, r, e, lat, t);
    checks++; if (r !== 32'h0000BEEF) begin errors++; $display("FAIL ld_half_u rdata got %h exp 0000beef", r); end
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int lat; time t;
    run_txn(1'b0, 1'b0, 12'h011, 2'b01, 1'b0, 32'h0, r, e, lat, t);
`ifdef DMEM_MISALIGN_CHECK_EN
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL misalign err got %b exp 1", e); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL misalign rdata got %h exp 0", r); end
`else
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL misalign err got %b exp 0", e); end
    checks++; if (r !== 32'h0000BEEF) begin errors++; $display("FAIL misalign rdata got %h exp 0000beef", r); end
`endif
    run_txn(1'b0, 1'b1, 12'h010, 2'b11, 1'b0, 32'hFFFFFFFF, r, e, lat, t);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL rsvd err got %b exp 1", e); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rsvd rdata got %h exp 0", r); end
    run_txn(1'b0, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, r, e, lat, t);
    checks++; if (r !== 32'h80ADBEEF) begin errors++; $display("FAIL rsvd_nowrite rdata got %h exp 80adbeef", r); end
  endtask

  task automatic test_hold();
    int n;
    @(negedge clk);
    rsp_ready = 1'b0;
    wr = 1'b0; addr = 12'h010; size = 2'b10; sgn = 1'b0; wdata = 32'h0; v2 = 1'b1;
    n = 0;
    while (!rdy2 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0;
    n = 1;
    while (!val2 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL hold latency got %0d exp 3", n); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (val2 !== 1'b1) begin errors++; $display("FAIL hold%0d rsp_valid got %b exp 1", i, val2); end
      checks++; if (rd2 !== 32'h80ADBEEF) begin errors++; $display("FAIL hold%0d rdata got %h exp 80adbeef", i, rd2); end
      checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL hold%0d req_ready got %b exp 0", i, rdy2); end
    end
    $display("txn dut2 hold load 010 released after 5 stalled cycles");
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (val2 !== 1'b0) begin errors++; $display("FAIL release rsp_valid got %b exp 0", val2); end
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL release req_ready got %b exp 1", rdy2); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] r; logic e; int lat; time t; int n;
    run_txn(1'b0, 1'b1, 12'h020, 2'b10, 1'b0, 32'hCAFEF00D, r, e, lat, t);
    // Reset while the store sits in WAIT: it must be abandoned.
    @(negedge clk);
    wr = 1'b1; addr = 12'h020; size = 2'b10; wdata = 32'h12345678; v2 = 1'b1;
    n = 0;
    while (!rdy2 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL rst_wait req_ready got %b exp 1", rdy2); end
    checks++; if (val2 !== 1'b0) begin errors++; $display("FAIL rst_wait rsp_valid got %b exp 0", val2); end
    $display("txn dut2 store 12345678 @020 abandoned by reset in WAIT");
    @(negedge clk);
    rst = 1'b1;
    run_txn(1'b0, 1'b0, 12'h020, 2'b10, 1'b0, 32'h0, r, e, lat, t);
    checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_wait_nowrite rdata got %h exp cafef00d", r); end
    // Reset while a store is responding: response dropped, write kept.
    @(negedge clk);
    rsp_ready = 1'b0;
    wr = 1'b1; addr = 12'h024; size = 2'b10; wdata = 32'h11223344; v2 = 1'b1;
    n = 0;
    while (!rdy2 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0;
    n = 1;
    while (!val2 && n < 20) begin @(negedge clk); n++; end
    #1 rst = 1'b0;
    #1;
    checks++; if (val2 !== 1'b0) begin errors++; $display("FAIL rst_resp rsp_valid got %b exp 0", val2); end
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL rst_resp req_ready got %b exp 1", rdy2); end
    $display("txn dut2 store 11223344 @024 response dropped by reset in RESP");
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    run_txn(1'b0, 1'b0, 12'h024, 2'b10, 1'b0, 32'h0, r, e, lat, t);
    checks++; if (r !== 32'h11223344) begin errors++; $display("FAIL rst_resp_kept rdata got %h exp 11223344", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic e; int lat; time t1, t2, t3, t4;
    run_txn(1'b1, 1'b1, 12'h004, 2'b10, 1'b0, 32'hA5A5A5A5, r, e, lat, t1);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b0 latency got %0d exp 1", lat); end
    run_txn(1'b1, 1'b1, 12'h008, 2'b10, 1'b0, 32'h5A5A0F0F, r, e, lat, t2);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b1 latency got %0d exp 1", lat); end
    checks++; if (t2 - t1 !== 20) begin errors++; $display("FAIL b2b1 interval got %0t exp 20", t2 - t1); end
    // Word 17 wraps onto word 1 of the 16-word instance.
    run_txn(1'b1, 1'b0, 12'h044, 2'b10, 1'b0, 32'h0, r, e, lat, t3);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b2 latency got %0d exp 1", lat); end
    checks++; if (t3 - t2 !== 20) begin errors++; $display("FAIL b2b2 interval got %0t exp 20", t3 - t2); end
    checks++; if (r !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap rdata got %h exp a5a5a5a5", r); end
    run_txn(1'b1, 1'b0, 12'h00A, 2'b01, 1'b0, 32'h0, r, e, lat, t4);
    checks++; if (t4 - t3 !== 20) begin errors++; $display("FAIL b2b3 interval got %0t exp 20", t4 - t3); end
    checks++; if (r !== 32'h00005A5A) begin errors++; $display("FAIL b2b3 rdata got %h exp 00005a5a", r); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_hold();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait states between request acceptance and response (range 0..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, giving the 32-bit word count of storage (4 KiB).
REQ-003 SHALL have port clk, input, 1 bit, the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit, meaning the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit, meaning the responder can accept a request this cycle.
REQ-007 SHALL have port req_wr, input, 1 bit; 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 12 bits, a byte address.
REQ-009 SHALL have port req_size, input, 2 bits, encoding 00 = byte, 01 = half, 10 = word; 11 is reserved.
REQ-010 SHALL have port req_signed, input, 1 bit, selecting sign-extension for byte/half loads.
REQ-011 SHALL have port req_wdata, input, 32 bits, the store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1 bit, meaning the response is available.
REQ-013 SHALL have port rsp_ready, input, 1 bit, meaning the initiator accepts the response.
REQ-014 SHALL have port rsp_rdata, output, 32 bits, the extended load data; 0 for stores.
REQ-015 SHALL have port rsp_err, output, 1 bit, the access error flag.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; a handshake is req_valid&req_ready at a clock edge.
REQ-018 On handshake, SHALL latch wr/addr/size/signed/wdata into internal registers, load the wait counter with WAIT_CYCLES, and go to WAIT (or directly to RESP if WAIT_CYCLES=0).
REQ-019 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-020 SHALL assert rsp_valid exactly WAIT_CYCLES+1 cycles after the accepting edge, and hold it, with rsp_rdata/rsp_err stable, until rsp_valid&rsp_ready.
REQ-021 On response handshake, SHALL return to IDLE; a new request SHALL NOT be accepted in the same edge (back-to-back throughput is one per WAIT_CYCLES+2 cycles).
REQ-022 SHALL commit a store to storage on the edge entering RESP, writing only the addressed byte lanes: byte selects lane addr[1:0], half selects lanes {addr[1],0}, word selects all four lanes.
REQ-023 Load data SHALL be sampled from the word addr[11:2] on the edge entering RESP, lane-selected, then zero- or sign-extended per req_signed; word loads ignore req_signed.
REQ-024 req_size=11 SHALL produce rsp_err=1, no write, and rsp_rdata=0.
REQ-025 Addresses beyond DEPTH_WORDS*4 SHALL wrap modulo the depth.
REQ-026 Storage contents SHALL NOT be initialised by reset.

Reset
REQ-027 Asserting rst (low) SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and counter=0.
REQ-028 Reset in WAIT SHALL abandon the request with no write performed; reset in RESP SHALL drop the response while keeping the committed write.

Configuration
REQ-029 With macro DMEM_MISALIGN_CHECK_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL give rsp_err=1, no write, and rsp_rdata=0.
REQ-030 Without DMEM_MISALIGN_CHECK_EN, the offending low address bits SHALL be forced to 0 and the access completes with rsp_err=0.

Structure
REQ-031 A shared package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type.
REQ-032 Storage SHALL be a sub-module dmem_array: DEPTH_WORDS x 32 bits, 4-bit byte-write-enable, synchronous write and synchronous read.

Verification
REQ-033 Reset, then WAIT_CYCLES=2, store word 0xDEADBEEF to address 0x010 -> rsp_valid high at the 3rd edge after acceptance; then load word from 0x010 -> rsp_rdata=0xDEADBEEF.
REQ-034 Store byte 0x80 to address 0x013, then signed byte load from 0x013 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load from 0x010 -> 0x80ADBEEF.
REQ-035 Half load from address 0x011 with the macro defined -> rsp_err=1, rsp_rdata=0; without the macro -> reads the half at 0x010 with rsp_err=0.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0; release rsp_ready -> IDLE on the next edge.
REQ-037 Assert rst during WAIT of a store of 0x12345678 to address 0x020 -> no write occurs, and a subsequent load from 0x020 returns the prior contents.
REQ-038 Run WAIT_CYCLES=0 with back-to-back requests -> each response arrives 1 edge after acceptance, one transaction every 2 cycles.
